// File: rtl/ex_stage_alu_reg.sv
// EX pipeline stage: resolves rs/rt forwarding from EX/MEM and MEM/WB, executes the
// ALU operation and captures the result, zero flag and control bits in the EX/MEM register.
module ex_stage_alu_reg #(
    parameter int WIDTH   = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [3:0]         ctrl,
    input  logic               alu_src,
    input  logic [WIDTH-1:0]   rs_data,
    input  logic [WIDTH-1:0]   rt_data,
    input  logic [WIDTH-1:0]   imm,
    input  logic [RADDR_W-1:0] rs_addr,
    input  logic [RADDR_W-1:0] rt_addr,
    input  logic [RADDR_W-1:0] rd_addr,
    input  logic               reg_dst,
    input  logic               reg_write,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               mem_to_reg,
    input  logic               wb_write,
    input  logic [RADDR_W-1:0] wb_dst,
    input  logic [WIDTH-1:0]   wb_data,
    input  logic               hold,
    input  logic               flush,
    output logic               em_valid,
    output logic               em_reg_write,
    output logic               em_mem_read,
    output logic               em_mem_write,
    output logic               em_mem_to_reg,
    output logic [WIDTH-1:0]   em_result,
    output logic               em_zero,
    output logic [WIDTH-1:0]   em_store,
    output logic [RADDR_W-1:0] em_dst,
    output logic               em_illegal
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // EX/MEM register contents
    logic               r_valid;
    logic               r_reg_write;
    logic               r_mem_read;
    logic               r_mem_write;
    logic               r_mem_to_reg;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic [WIDTH-1:0]   r_store;
    logic [RADDR_W-1:0] r_dst;
    logic               r_illegal;

    logic               w_em_fwd_ok;
    logic               w_em_hit_a;
    logic               w_em_hit_b;
    logic               w_wb_hit_a;
    logic               w_wb_hit_b;
    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH-1:0]   w_fwd_b;
    logic [WIDTH-1:0]   w_op_b;
    logic [WIDTH-1:0]   w_result;
    logic               w_illegal;
    logic [RADDR_W-1:0] w_dst;
    logic               w_bubble;

    // A load sitting in EX/MEM has no data yet, so it never forwards; r0 never forwards.
    assign w_em_fwd_ok = r_valid & r_reg_write & ~r_mem_read;
    assign w_em_hit_a  = w_em_fwd_ok && (r_dst == rs_addr) && (rs_addr != '0);
    assign w_em_hit_b  = w_em_fwd_ok && (r_dst == rt_addr) && (rt_addr != '0);
    assign w_wb_hit_a  = wb_write && (wb_dst == rs_addr) && (rs_addr != '0);
    assign w_wb_hit_b  = wb_write && (wb_dst == rt_addr) && (rt_addr != '0);

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    assign w_op_a  = w_em_hit_a ? r_result : (w_wb_hit_a ? wb_data : rs_data);
    assign w_fwd_b = w_em_hit_b ? r_result : (w_wb_hit_b ? wb_data : rt_data);
    assign w_op_b  = alu_src ? imm : w_fwd_b;

    assign w_dst    = reg_write ? (reg_dst ? rd_addr : rt_addr) : '0;
    assign w_bubble = flush | (~hold & ~in_valid);

    // ALU: decode ctrl and compute the result; unknown codes yield 0 and flag illegal.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_result  = '0;
        w_illegal = 1'b0;
        case (ctrl)
            ALU_ADD: w_result = w_op_a + w_op_b;
            ALU_SUB: w_result = w_op_a - w_op_b;
            ALU_AND: w_result = w_op_a & w_op_b;
            ALU_OR:  w_result = w_op_a | w_op_b;
            ALU_SLT: w_result = {{(WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            default: w_illegal = 1'b1;
        endcase
    end

    // EX/MEM register update: flush beats hold beats load; an invalid slot loads a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_store      <= '0;
            r_dst        <= '0;
            r_illegal    <= 1'b0;
        end else if (w_bubble) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_store      <= '0;
            r_dst        <= '0;
            r_illegal    <= 1'b0;
        end else if (!hold) begin
            r_valid      <= 1'b1;
            r_reg_write  <= reg_write;
            r_mem_read   <= mem_read;
            r_mem_write  <= mem_write;
            r_mem_to_reg <= mem_to_reg;
            r_result     <= w_result;
            r_zero       <= (w_result == '0);
            r_store      <= w_fwd_b;
            r_dst        <= w_dst;
            r_illegal    <= w_illegal;
        end
    end

    assign em_valid      = r_valid;
    assign em_reg_write  = r_reg_write;
    assign em_mem_read   = r_mem_read;
    assign em_mem_write  = r_mem_write;
    assign em_mem_to_reg = r_mem_to_reg;
    assign em_result     = r_result;
    assign em_zero       = r_zero;
    assign em_store      = r_store;
    assign em_dst        = r_dst;
    assign em_illegal    = r_illegal;

endmodule

// File: tb/tb_ex_stage_alu_reg.sv
// Self-checking bench for ex_stage_alu_reg: directed cases plus randomized traffic,
// all compared against a behavioural model of the EX/MEM register.
module tb_ex_stage_alu_reg;

    localparam int WIDTH   = 32;
    localparam int RADDR_W = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic [3:0]         ctrl;
    logic               alu_src;
    logic [WIDTH-1:0]   rs_data, rt_data, imm, wb_data;
    logic [RADDR_W-1:0] rs_addr, rt_addr, rd_addr, wb_dst;
    logic               reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
    logic               wb_write, hold, flush;
    logic               em_valid, em_reg_write, em_mem_read, em_mem_write, em_mem_to_reg;
    logic [WIDTH-1:0]   em_result, em_store;
    logic               em_zero, em_illegal;
    logic [RADDR_W-1:0] em_dst;

    always #5 clk = ~clk;

    ex_stage_alu_reg #(.WIDTH(WIDTH), .RADDR_W(RADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ctrl(ctrl), .alu_src(alu_src),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .reg_dst(reg_dst), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .wb_write(wb_write), .wb_dst(wb_dst), .wb_data(wb_data),
        .hold(hold), .flush(flush),
        .em_valid(em_valid), .em_reg_write(em_reg_write), .em_mem_read(em_mem_read),
        .em_mem_write(em_mem_write), .em_mem_to_reg(em_mem_to_reg),
        .em_result(em_result), .em_zero(em_zero), .em_store(em_store),
        .em_dst(em_dst), .em_illegal(em_illegal)
    );

    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               illegal;
        logic               zero;
        logic [WIDTH-1:0]   result;
        logic [WIDTH-1:0]   store;
        logic [RADDR_W-1:0] dst;
    } em_t;

    em_t m;
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Value an operand reads: newest valid non-load producer first, then write-back, else ID/EX.
    function automatic logic [WIDTH-1:0] operand(input em_t cur, input int addr, input logic [WIDTH-1:0] idv);
        if (addr == 0) return idv;
        if (cur.valid && cur.reg_write && !cur.mem_read && int'(cur.dst) == addr) return cur.result;
        if (wb_write && int'(wb_dst) == addr) return wb_data;
        return idv;
    endfunction

    function automatic em_t model_next(input em_t cur);
        em_t n;
        longint unsigned a, b, r;
        n = '0;
        if (flush) return n;
        if (hold) return cur;
        if (!in_valid) return n;
        a = operand(cur, int'(rs_addr), rs_data);
        b = alu_src ? imm : operand(cur, int'(rt_addr), rt_data);
        r = 0;
        case (int'(ctrl))
            2:  r = (a + b) % (64'd1 << WIDTH);
            6:  r = (a + (64'd1 << WIDTH) - b) % (64'd1 << WIDTH);
            0:  r = a & b;
            1:  r = a | b;
            7:  r = (int'(a[WIDTH-1:0]) < int'(b[WIDTH-1:0])) ? 1 : 0;
            default: n.illegal = 1'b1;
        endcase
        n.valid      = 1'b1;
        n.reg_write  = reg_write;
        n.mem_read   = mem_read;
        n.mem_write  = mem_write;
        n.mem_to_reg = mem_to_reg;
        n.result     = r[WIDTH-1:0];
        n.zero       = (r == 0);
        n.store      = operand(cur, int'(rt_addr), rt_data);
        n.dst        = reg_write ? (reg_dst ? rd_addr : rt_addr) : '0;
        return n;
    endfunction

    task automatic compare_all();
        check("valid",      em_valid,      m.valid);
        check("reg_write",  em_reg_write,  m.reg_write);
        check("mem_read",   em_mem_read,   m.mem_read);
        check("mem_write",  em_mem_write,  m.mem_write);
        check("mem_to_reg", em_mem_to_reg, m.mem_to_reg);
        check("illegal",    em_illegal,    m.illegal);
        check("zero",       em_zero,       m.zero);
        check("result",     em_result,     m.result);
        check("store",      em_store,      m.store);
        check("dst",        em_dst,        m.dst);
    endtask

    // One clock: update the model at the edge, compare just after it, return at the negedge.
    task automatic step();
        @(posedge clk);
        m = model_next(m);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic drive_op(input logic [3:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [RADDR_W-1:0] ra, input logic [RADDR_W-1:0] rb,
                            input logic [RADDR_W-1:0] rd);
        in_valid = 1'b1; ctrl = c; alu_src = 1'b0; imm = '0;
        rs_data = a; rt_data = b; rs_addr = ra; rt_addr = rb; rd_addr = rd;
        reg_dst = 1'b1; reg_write = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
        wb_write = 1'b0; wb_dst = '0; wb_data = '0; hold = 1'b0; flush = 1'b0;
    endtask

    initial begin
        logic [3:0] legal [5];
        legal[0] = 4'b0000; legal[1] = 4'b0001; legal[2] = 4'b0010;
        legal[3] = 4'b0110; legal[4] = 4'b0111;

        m = '0;
        rst_n = 1'b0;
        drive_op(4'b0010, '0, '0, '0, '0, '0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        @(negedge clk);

        // Basic arithmetic and logic
        drive_op(4'b0010, 32'd5, 32'd7, 5'd1, 5'd2, 5'd4);
        step();
        check("add_result", em_result, 64'd12);
        check("add_zero", em_zero, 64'd0);
        drive_op(4'b0110, 32'd7, 32'd7, 5'd1, 5'd2, 5'd5);
        step();
        check("sub_result", em_result, 64'd0);
        check("sub_zero", em_zero, 64'd1);
        drive_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd1, 5'd2, 5'd6);
        step();
        check("slt_result", em_result, 64'd1);
        drive_op(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 5'd1, 5'd2, 5'd7);
        step();
        check("and_result", em_result, 64'h00F0);
        drive_op(4'b0001, 32'h0000_F0F0, 32'h0000_0FF0, 5'd1, 5'd2, 5'd8);
        step();
        check("or_result", em_result, 64'hFFF0);

        // Forwarding priority, then r0 never forwards
        drive_op(4'b0010, 32'd4, 32'd5, 5'd1, 5'd2, 5'd3);
        step();
        drive_op(4'b0010, 32'd100, 32'd0, 5'd3, 5'd0, 5'd9);
        wb_write = 1'b1; wb_dst = 5'd3; wb_data = 32'd4;
        step();
        check("fwd_em_priority", em_result, 64'd9);
        drive_op(4'b0010, 32'd4, 32'd5, 5'd1, 5'd2, 5'd0);
        step();
        drive_op(4'b0010, 32'd100, 32'd0, 5'd0, 5'd0, 5'd9);
        wb_write = 1'b1; wb_dst = 5'd0; wb_data = 32'd4;
        step();
        check("fwd_r0_none", em_result, 64'd100);

        // Hold freezes, flush wins over hold
        drive_op(4'b0110, 32'd50, 32'd1, 5'd1, 5'd2, 5'd10);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_result", em_result, 64'd100);
            check("hold_dst", em_dst, 64'd9);
        end
        flush = 1'b1;
        step();
        check("flush_valid", em_valid, 64'd0);
        check("flush_reg_write", em_reg_write, 64'd0);

        // Illegal opcode, then a legal op clears the flag
        drive_op(4'b1111, 32'd3, 32'd4, 5'd1, 5'd2, 5'd5);
        step();
        check("illegal_result", em_result, 64'd0);
        check("illegal_flag", em_illegal, 64'd1);
        check("illegal_zero", em_zero, 64'd1);
        check("illegal_valid", em_valid, 64'd1);
        drive_op(4'b0010, 32'd1, 32'd1, 5'd1, 5'd2, 5'd5);
        step();
        check("illegal_cleared", em_illegal, 64'd0);

        // Reset asserted between edges clears outputs immediately
        drive_op(4'b0010, 32'd20, 32'd22, 5'd1, 5'd2, 5'd6);
        step();
        rst_n = 1'b0;
        #1;
        m = '0;
        check("rst_valid", em_valid, 64'd0);
        check("rst_result", em_result, 64'd0);
        check("rst_dst", em_dst, 64'd0);
        compare_all();
        #2;
        rst_n = 1'b1;
        step();

        // Randomized traffic with small address space to exercise forwarding
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 9) != 0);
            ctrl       = ($urandom_range(0, 9) == 0) ? 4'($urandom) : legal[$urandom_range(0, 4)];
            alu_src    = 1'($urandom);
            rs_data    = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
            rt_data    = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
            imm        = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 3);
            rs_addr    = 5'($urandom_range(0, 3));
            rt_addr    = 5'($urandom_range(0, 3));
            rd_addr    = 5'($urandom_range(0, 3));
            reg_dst    = 1'($urandom);
            reg_write  = ($urandom_range(0, 3) != 0);
            mem_read   = ($urandom_range(0, 3) == 0);
            mem_write  = ($urandom_range(0, 3) == 0);
            mem_to_reg = 1'($urandom);
            wb_write   = 1'($urandom);
            wb_dst     = 5'($urandom_range(0, 3));
            wb_data    = $urandom;
            hold       = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 11) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
